// File: rtl/instr_dispatch_fsm.sv
// instr_dispatch_fsm: fetches and decodes instruction words, strobes the matching
// MOV/ALU/JMP engine and waits for its done before advancing the PC.
module instr_dispatch_fsm #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16,
    parameter int TMO_CYC = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    output logic [PC_W-1:0]    pmAddr,
    output logic               pmRdEn,
    input  logic [INSTR_W-1:0] pmData,
    output logic [3:0]         opCode,
    output logic               MOVstr,
    output logic               ALUstr,
    output logic               JMPstr,
    input  logic               MOVdone,
    input  logic               ALUdone,
    input  logic               JMPdone,
    input  logic               jmpTake,
    input  logic [PC_W-1:0]    jmpTarget,
    output logic               halted,
    output logic               err
);
    localparam int WD_W = $clog2(TMO_CYC);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_DECODE, S_EXEC, S_HALT} state_t;

    state_t             r_state, w_next;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [WD_W-1:0]    r_wd;
    logic               r_movstr, r_alustr, r_jmpstr, r_err;
    logic [3:0]         w_ld_op, w_op;
    logic               w_done, w_tmo, w_unused;

    assign w_ld_op  = pmData[INSTR_W-1 -: 4];
    assign w_op     = r_ir[INSTR_W-1 -: 4];
    assign w_unused = ^r_ir[INSTR_W-5:0];
    // only the engine selected by the held opcode can complete the instruction
    assign w_done   = (!w_op[3] && ALUdone) || (w_op[3:2] == 2'b10 && MOVdone) ||
                      (w_op[3:2] == 2'b11 && JMPdone);
    assign w_tmo    = r_wd == WD_W'(TMO_CYC - 1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = run ? S_FETCH : S_IDLE;
            S_FETCH:  w_next = S_LOAD;
            S_LOAD:   w_next = S_DECODE;
            S_DECODE: w_next = (w_op == 4'hF) ? S_HALT : S_EXEC;
            S_EXEC:   w_next = w_done ? (run ? S_FETCH : S_IDLE) : (w_tmo ? S_HALT : S_EXEC);
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_ir     <= '0;
            r_wd     <= '0;
            r_movstr <= 1'b0;
            r_alustr <= 1'b0;
            r_jmpstr <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_next;
            if (r_state == S_LOAD) r_ir <= pmData;
            // strobes are set while loading so they are high exactly in the DECODE cycle
            r_movstr <= r_state == S_LOAD && w_ld_op[3:2] == 2'b10;
            r_alustr <= r_state == S_LOAD && !w_ld_op[3];
            r_jmpstr <= r_state == S_LOAD && w_ld_op[3:2] == 2'b11 && w_ld_op != 4'hF;
            if (r_state == S_DECODE) r_wd <= '0;
            else if (r_state == S_EXEC && !w_done) r_wd <= r_wd + 1'b1;
            if (r_state == S_EXEC && w_done)
                r_pc <= (w_op[3:2] == 2'b11 && jmpTake) ? jmpTarget : r_pc + 1'b1;
            if (r_state == S_EXEC && !w_done && w_tmo) r_err <= 1'b1;
        end
    end

    assign pmAddr = r_pc;
    assign pmRdEn = r_state == S_FETCH;
    assign opCode = w_op;
    assign MOVstr = r_movstr;
    assign ALUstr = r_alustr;
    assign JMPstr = r_jmpstr;
    assign halted = r_state == S_HALT;
    assign err    = r_err;
endmodule

// File: tb/tb_instr_dispatch_fsm.sv
// tb_instr_dispatch_fsm: table-driven, hand-written and random instruction streams
// checked against a per-instruction PC/strobe model.
module tb_instr_dispatch_fsm;
    logic        clk = 1'b0, reset, run;
    logic [7:0]  pmAddr, jmpTarget;
    logic        pmRdEn, MOVstr, ALUstr, JMPstr, MOVdone, ALUdone, JMPdone, jmpTake, halted, err;
    logic [15:0] pmData;
    logic [3:0]  opCode;
    logic [15:0] mem [256];
    logic [7:0]  m_pc;
    int          n_chk = 0, n_fail = 0;

    instr_dispatch_fsm #(.PC_W(8), .INSTR_W(16), .TMO_CYC(8)) dut (
        .clk(clk), .reset(reset), .run(run), .pmAddr(pmAddr), .pmRdEn(pmRdEn), .pmData(pmData),
        .opCode(opCode), .MOVstr(MOVstr), .ALUstr(ALUstr), .JMPstr(JMPstr), .MOVdone(MOVdone),
        .ALUdone(ALUdone), .JMPdone(JMPdone), .jmpTake(jmpTake), .jmpTarget(jmpTarget),
        .halted(halted), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (pmRdEn) pmData <= mem[pmAddr];

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    typedef struct {
        logic [3:0] op;
        int         dly;
        logic       take;
        logic [7:0] tgt;
        logic       drop;
        logic       dis;
        logic [2:0] es;
        logic [7:0] ep;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] outs();
        return {pmAddr, pmRdEn, opCode, MOVstr, ALUstr, JMPstr, halted, err};
    endfunction

    // {MOV,ALU,JMP} engine selected by an opcode, from the class ranges
    function automatic logic [2:0] cls(input logic [3:0] op);
        return op < 8 ? 3'b010 : op < 12 ? 3'b100 : op < 15 ? 3'b001 : 3'b000;
    endfunction

    task automatic do_reset();
        reset = 1'b0; run = 1'b0; {MOVdone, ALUdone, JMPdone, jmpTake} = '0; jmpTarget = '0;
        repeat (2) @(negedge clk);
        chk("reset_state", outs(), 0);
        reset = 1'b1;
        m_pc = '0;
    endtask

    task automatic wait_fetch();
        int i = 0;
        while (!pmRdEn && i < 6) begin
            @(negedge clk);
            i++;
        end
        chk("fetch_seen", pmRdEn, 1);
        chk("fetch_addr", pmAddr, m_pc);
    endtask

    task automatic run_instr(input logic [3:0] op, input int dly, input logic take,
                             input logic [7:0] tgt, input logic drop, input logic dis,
                             input logic [2:0] es, input logic [7:0] ep);
        wait_fetch();
        mem[m_pc] = {op, 12'($urandom)};
        @(negedge clk);
        chk("load_quiet", {pmRdEn, MOVstr, ALUstr, JMPstr}, 0);
        @(negedge clk);
        chk("strobe", {MOVstr, ALUstr, JMPstr}, es);
        chk("opcode", opCode, op);
        if (drop) run = 1'b0;
        jmpTake = take; jmpTarget = tgt;
        {MOVdone, ALUdone, JMPdone} = dis ? es : 3'b000;
        for (int k = 0; k <= dly; k++) begin
            @(negedge clk);
            chk("exec_quiet", {MOVstr, ALUstr, JMPstr, pmRdEn, halted, err}, 0);
            chk("pc_hold", pmAddr, m_pc);
            if (k == dly) {MOVdone, ALUdone, JMPdone} = es;
            else {MOVdone, ALUdone, JMPdone} = dis ? (3'($urandom) & ~es) : 3'b000;
        end
        @(negedge clk);
        {MOVdone, ALUdone, JMPdone} = '0;
        m_pc = ep;
        chk("next_pc", pmAddr, ep);
        chk("refetch", pmRdEn, !drop);
        if (drop) begin
            repeat (3) begin
                @(negedge clk);
                chk("parked", {pmRdEn, MOVstr, ALUstr, JMPstr, pmAddr}, {4'b0, ep});
            end
            run = 1'b1;
        end
    endtask

    task automatic run_halt();
        wait_fetch();
        mem[m_pc] = {4'hF, 12'($urandom)};
        repeat (2) @(negedge clk);
        chk("halt_nostrobe", {MOVstr, ALUstr, JMPstr}, 0);
        chk("halt_opcode", opCode, 4'hF);
        repeat (5) begin
            @(negedge clk);
            chk("halted", {halted, err, pmRdEn, MOVstr, ALUstr, JMPstr, pmAddr}, {6'b100000, m_pc});
        end
    endtask

    task automatic run_tmo();
        wait_fetch();
        mem[m_pc] = {4'h9, 12'($urandom)};
        repeat (2) @(negedge clk);
        chk("tmo_strobe", {MOVstr, ALUstr, JMPstr}, 3'b100);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("tmo_wait", {halted, err}, 0);
            ALUdone = ~ALUdone;
            JMPdone = 1'b1; jmpTake = 1'b1; jmpTarget = 8'h44;
        end
        @(negedge clk);
        {ALUdone, JMPdone, jmpTake} = '0;
        chk("tmo_err", {halted, err, pmRdEn}, 3'b110);
        chk("tmo_pc", pmAddr, m_pc);
    endtask

    initial begin
        tbl[0]  = '{4'h9, 1, 1'b0, 8'h00, 1'b0, 1'b0, 3'b100, 8'h01};
        tbl[1]  = '{4'h3, 0, 1'b0, 8'h00, 1'b0, 1'b0, 3'b010, 8'h02};
        tbl[2]  = '{4'hC, 2, 1'b1, 8'h05, 1'b0, 1'b0, 3'b001, 8'h05};
        tbl[3]  = '{4'hC, 0, 1'b1, 8'h20, 1'b0, 1'b0, 3'b001, 8'h20};
        tbl[4]  = '{4'hD, 3, 1'b0, 8'h77, 1'b0, 1'b0, 3'b001, 8'h21};
        tbl[5]  = '{4'h0, 7, 1'b0, 8'h00, 1'b0, 1'b1, 3'b010, 8'h22};
        tbl[6]  = '{4'h7, 2, 1'b1, 8'h99, 1'b0, 1'b1, 3'b010, 8'h23};
        tbl[7]  = '{4'h8, 0, 1'b0, 8'h00, 1'b1, 1'b0, 3'b100, 8'h24};
        tbl[8]  = '{4'hB, 4, 1'b1, 8'h66, 1'b0, 1'b1, 3'b100, 8'h25};
        tbl[9]  = '{4'hE, 1, 1'b1, 8'hFF, 1'b0, 1'b0, 3'b001, 8'hFF};
        tbl[10] = '{4'h1, 0, 1'b0, 8'h00, 1'b0, 1'b0, 3'b010, 8'h00};
        tbl[11] = '{4'hA, 0, 1'b0, 8'h00, 1'b0, 1'b0, 3'b100, 8'h01};
        tbl[12] = '{4'hC, 0, 1'b1, 8'h05, 1'b0, 1'b0, 3'b001, 8'h05};
        tbl[13] = '{4'hC, 1, 1'b0, 8'h40, 1'b0, 1'b1, 3'b001, 8'h06};
        for (int i = 0; i < 256; i++) mem[i] = '0;

        do_reset();
        run = 1'b1;
        foreach (tbl[i])
            run_instr(tbl[i].op, tbl[i].dly, tbl[i].take, tbl[i].tgt, tbl[i].drop, tbl[i].dis,
                      tbl[i].es, tbl[i].ep);

        // asynchronous reset while fetching, then while a strobe is high
        wait_fetch();
        #1 reset = 1'b0;
        #1 chk("async_rst_fetch", outs(), 0);
        @(negedge clk) reset = 1'b1;
        m_pc = '0;
        wait_fetch();
        mem[0] = 16'h9123;
        repeat (2) @(negedge clk);
        chk("pre_rst_strobe", MOVstr, 1);
        #1 reset = 1'b0;
        #1 chk("async_rst_decode", outs(), 0);
        @(negedge clk) reset = 1'b1;
        run_instr(4'h3, 0, 1'b0, 8'h00, 1'b0, 1'b0, 3'b010, 8'h01);

        for (int n = 0; n < 150; n++) begin
            logic [3:0] op;
            logic       take;
            logic [7:0] tgt, ep;
            op   = 4'($urandom_range(0, 14));
            take = 1'($urandom);
            tgt  = 8'($urandom);
            ep   = (cls(op) == 3'b001 && take) ? tgt : 8'((m_pc + 1) % 256);
            run_instr(op, $urandom_range(0, 7), take, tgt, ($urandom_range(0, 7) == 0),
                      1'($urandom), cls(op), ep);
        end

        do_reset();
        run = 1'b1;
        run_tmo();

        do_reset();
        run = 1'b1;
        run_instr(4'h3, 0, 1'b0, 8'h00, 1'b0, 1'b0, 3'b010, 8'h01);
        run_halt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
